// File: rtl/ysyx_25020037_ifu_pkg.sv
// Shared IFU configuration: bus width, FSM encodings, EBREAK word and default boot PC.
// Imported by the IFU; also consulted by the optional YSYX_25020037_IFU_ALIGN_CHK_EN check.
package ysyx_25020037_ifu_pkg;

    localparam int          FU_TO_DU_BUS_WD  = 64;
    localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h3000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_IDLE = 2'd3
    } ifu_state_e;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_25020037_ifu.sv
// Instruction fetch unit: PC register, one AXI4-Lite-style read per retired instruction, {pc, inst} to the IDU.
// Define YSYX_25020037_IFU_ALIGN_CHK_EN to turn misaligned PCs into a faulted EBREAK without a bus read.
module ysyx_25020037_ifu
    import ysyx_25020037_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wbu_valid,
    input  logic [31:0]                next_pc,
    output logic                       arvalid,
    output logic [31:0]                araddr,
    input  logic                       arready,
    input  logic                       rvalid,
    input  logic [31:0]                rdata,
    input  logic [1:0]                 rresp,
    output logic                       rready,
    output logic                       ifu_valid,
    output logic [FU_TO_DU_BUS_WD-1:0] fu_to_du_bus,
    output logic                       fetch_fault,
    output logic [1:0]                 dbg_state
);

    // Handshake: a beat transfers on a clock edge where valid and ready are both high;
    // arvalid/araddr never change while waiting for arready, rready is high only in R.
    ifu_state_e                 state, state_nxt;
    logic [31:0]                pc, pc_nxt;
    logic [FU_TO_DU_BUS_WD-1:0] bus, bus_nxt;
    logic                       valid_q, valid_nxt;
    logic                       fault_q, fault_nxt;
    logic                       rd_err;

    assign rd_err = (rresp != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        bus_nxt   = bus;
        valid_nxt = 1'b0;
        fault_nxt = 1'b0;
        case (state)
            ST_BOOT: begin
                pc_nxt    = RESET_PC;
                state_nxt = ST_AR;
`ifdef YSYX_25020037_IFU_ALIGN_CHK_EN
                if (misaligned(RESET_PC)) begin
                    state_nxt = ST_IDLE;
                    valid_nxt = 1'b1;
                    fault_nxt = 1'b1;
                    bus_nxt   = {RESET_PC, EBREAK_INST};
                end
`endif
            end
            ST_AR: begin
                if (arready) begin
                    state_nxt = ST_R;
                end
            end
            ST_R: begin
                if (rvalid) begin
                    state_nxt = ST_IDLE;
                    valid_nxt = 1'b1;
                    fault_nxt = rd_err;
                    bus_nxt   = {pc, rd_err ? EBREAK_INST : rdata};
                end
            end
            ST_IDLE: begin
                // wbu_valid outside IDLE is a protocol violation and is dropped here.
                if (wbu_valid) begin
                    pc_nxt    = next_pc;
                    state_nxt = ST_AR;
`ifdef YSYX_25020037_IFU_ALIGN_CHK_EN
                    if (misaligned(next_pc)) begin
                        state_nxt = ST_IDLE;
                        valid_nxt = 1'b1;
                        fault_nxt = 1'b1;
                        bus_nxt   = {next_pc, EBREAK_INST};
                    end
`endif
                end
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= '0;
            bus     <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            pc      <= pc_nxt;
            bus     <= bus_nxt;
            valid_q <= valid_nxt;
            fault_q <= fault_nxt;
        end
    end

    assign arvalid      = (state == ST_AR);
    assign araddr       = (state == ST_AR) ? pc : 32'h0;
    assign rready       = (state == ST_R);
    assign ifu_valid    = valid_q;
    assign fetch_fault  = fault_q;
    assign fu_to_du_bus = bus;
    assign dbg_state    = state;

endmodule

// File: tb/tb_ysyx_25020037_ifu.sv
// Self-checking bench for ysyx_25020037_ifu: vector table, hand-written corner sequences, random fetches vs a model.
// Honours YSYX_25020037_IFU_ALIGN_CHK_EN when it is defined for the build.
module tb_ysyx_25020037_ifu;

    localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;
    localparam logic [31:0] BOOT_PC     = 32'h3000_0000;
`ifdef YSYX_25020037_IFU_ALIGN_CHK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wbu_valid;
    logic [31:0] next_pc;
    logic        arvalid;
    logic [31:0] araddr;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rready;
    logic        ifu_valid;
    logic [63:0] fu_to_du_bus;
    logic        fetch_fault;
    logic [1:0]  dbg_state;

    ysyx_25020037_ifu dut (
        .clk          (clk),
        .rst          (rst),
        .wbu_valid    (wbu_valid),
        .next_pc      (next_pc),
        .arvalid      (arvalid),
        .araddr       (araddr),
        .arready      (arready),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .rresp        (rresp),
        .rready       (rready),
        .ifu_valid    (ifu_valid),
        .fu_to_du_bus (fu_to_du_bus),
        .fetch_fault  (fetch_fault),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [64:0] exp_q[$];

    typedef struct {
        logic [31:0] npc;
        int          ar_wait;
        int          r_wait;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        exp_fault;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: what the IDU should see for a fetch at pc with the given memory reply.
    function automatic logic [64:0] model(input logic [31:0] pc, input logic [31:0] data,
                                          input logic [1:0] resp);
        logic bad_align;
        bad_align = ALIGN_EN && (pc % 4 != 0);
        if (bad_align || resp != 2'b00) return {1'b1, pc, EBREAK_WORD};
        return {1'b0, pc, data};
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_arvalid"}, 64'(arvalid), 64'd0);
        chk({tag, "_araddr"}, 64'(araddr), 64'd0);
        chk({tag, "_rready"}, 64'(rready), 64'd0);
        chk({tag, "_ifu_valid"}, 64'(ifu_valid), 64'd0);
        chk({tag, "_fetch_fault"}, 64'(fetch_fault), 64'd0);
        chk({tag, "_bus"}, fu_to_du_bus, 64'd0);
    endtask

    task automatic expect_pulse(input string tag);
        logic [64:0] e;
        e = exp_q.pop_front();
        chk({tag, "_ifu_valid"}, 64'(ifu_valid), 64'd1);
        chk({tag, "_bus"}, fu_to_du_bus, e[63:0]);
        chk({tag, "_fault"}, 64'(fetch_fault), 64'(e[64]));
        step();
        chk({tag, "_pulse_end"}, 64'({ifu_valid, fetch_fault}), 64'd0);
    endtask

    // Entered on the negedge where the AR phase must already be visible.
    task automatic serve(input logic [31:0] addr, input int ar_wait, input int r_wait,
                         input logic [31:0] data, input logic [1:0] resp);
        logic stable;
        logic quiet;
        stable = 1'b1;
        quiet  = 1'b1;
        chk("arvalid_up", 64'(arvalid), 64'd1);
        chk("araddr", 64'(araddr), 64'(addr));
        for (int i = 0; i < ar_wait; i++) begin
            arready = 1'b0;
            step();
            if (arvalid !== 1'b1 || araddr !== addr || rready !== 1'b0) stable = 1'b0;
        end
        chk("ar_stable", 64'(stable), 64'd1);
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk("ar_drop_rready_up", 64'({arvalid, rready}), 64'd1);
        for (int i = 0; i < r_wait; i++) begin
            step();
            if (rready !== 1'b1 || ifu_valid !== 1'b0 || arvalid !== 1'b0) quiet = 1'b0;
        end
        chk("r_wait_quiet", 64'(quiet), 64'd1);
        rvalid = 1'b1;
        rdata  = data;
        rresp  = resp;
        step();
        rvalid = 1'b0;
        rdata  = $urandom;
        rresp  = 2'b00;
        chk("rready_drop", 64'(rready), 64'd0);
        expect_pulse("fetch");
    endtask

    task automatic fetch(input logic [31:0] npc, input int ar_wait, input int r_wait,
                         input logic [31:0] data, input logic [1:0] resp, input logic [64:0] exp);
        exp_q.push_back(exp);
        wbu_valid = 1'b1;
        next_pc   = npc;
        step();
        wbu_valid = 1'b0;
        next_pc   = $urandom;
        if (ALIGN_EN && npc[1:0] != 2'b00) begin
            chk("misalign_no_ar", 64'(arvalid), 64'd0);
            expect_pulse("misalign");
        end else begin
            serve(npc, ar_wait, r_wait, data, resp);
        end
    endtask

    // Releases rst just after a rising edge; one BOOT cycle follows before AR.
    task automatic release_reset(input logic [31:0] data, input int r_wait);
        exp_q.push_back(model(BOOT_PC, data, 2'b00));
        @(posedge clk);
        #1 rst = 1'b0;
        arready = 1'b1;
        @(negedge clk);
        chk("boot_no_ar", 64'(arvalid), 64'd0);
        step();
        serve(BOOT_PC, 0, r_wait, data, 2'b00);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic        quiet;
        logic [31:0] npc;
        logic [31:0] data;
        logic [1:0]  resp;
        int          aw;
        int          rw;

        vecs[0] = '{32'h3000_0004, 3, 2, 32'h00a0_0093, 2'b00, 1'b0, 32'h00a0_0093};
        vecs[1] = '{32'h3000_0008, 0, 0, 32'hdead_beef, 2'b10, 1'b1, EBREAK_WORD};
        vecs[2] = '{32'h3000_0010, 1, 0, 32'h1234_5678, 2'b01, 1'b1, EBREAK_WORD};
        vecs[3] = '{32'h8000_0000, 0, 3, 32'hffff_ffff, 2'b00, 1'b0, 32'hffff_ffff};
`ifdef YSYX_25020037_IFU_ALIGN_CHK_EN
        vecs[4] = '{32'h3000_0006, 0, 1, 32'h0000_0013, 2'b00, 1'b1, EBREAK_WORD};
`else
        vecs[4] = '{32'h3000_0006, 0, 1, 32'h0000_0013, 2'b00, 1'b0, 32'h0000_0013};
`endif

        rst = 1'b1; wbu_valid = 1'b0; next_pc = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");

        // Boot fetch with zero-wait memory, arready high before AR appears.
        release_reset(32'h0000_0413, 0);

        foreach (vecs[i]) begin
            fetch(vecs[i].npc, vecs[i].ar_wait, vecs[i].r_wait, vecs[i].data, vecs[i].resp,
                  {vecs[i].exp_fault, vecs[i].npc, vecs[i].exp_inst});
        end

        // wbu_valid during R is ignored; pc of the outstanding fetch is kept.
        exp_q.push_back({1'b0, 32'h3000_0020, 32'h0000_0513});
        wbu_valid = 1'b1; next_pc = 32'h3000_0020;
        step();
        wbu_valid = 1'b0;
        chk("wir_araddr", 64'(araddr), 64'h3000_0020);
        arready = 1'b1;
        step();
        arready = 1'b0;
        wbu_valid = 1'b1; next_pc = 32'h3000_0040;
        step();
        wbu_valid = 1'b0;
        chk("wir_still_r", 64'({arvalid, rready}), 64'd1);
        rvalid = 1'b1; rdata = 32'h0000_0513;
        step();
        rvalid = 1'b0;
        expect_pulse("wbu_in_r");
        quiet = 1'b1;
        repeat (3) begin
            step();
            if (arvalid !== 1'b0) quiet = 1'b0;
        end
        chk("wir_no_refetch", 64'(quiet), 64'd1);

        // Stray rvalid in IDLE is ignored.
        rvalid = 1'b1; rdata = 32'hcafe_f00d;
        step();
        rvalid = 1'b0;
        chk("stray_rvalid", 64'({rready, ifu_valid, fetch_fault}), 64'd0);
        fetch(32'h3000_0044, 0, 0, 32'h0000_0593, 2'b00, {1'b0, 32'h3000_0044, 32'h0000_0593});

        // Reset while in R abandons the beat and restarts at the boot PC.
        wbu_valid = 1'b1; next_pc = 32'h3000_0100;
        step();
        wbu_valid = 1'b0;
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk("rst_r_rready", 64'(rready), 64'd1);
        #1 rst = 1'b1;
        #1;
        check_reset("rst_in_r");
        repeat (2) @(posedge clk);
        release_reset(32'h0000_0297, 2);

        // Random fetches checked against the model.
        for (int k = 0; k < 24; k++) begin
            npc = $urandom;
            if ($urandom_range(0, 3) != 0) npc[1:0] = 2'b00;
            data = $urandom;
            resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            aw   = $urandom_range(0, 3);
            rw   = $urandom_range(0, 3);
            fetch(npc, aw, rw, data, resp, model(npc, data, resp));
        end

        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
